// File: rtl/mstream_pkg.sv
// Shared definitions for the matrix stream host.
// Holds the controller state encoding, the default element width, the
// maximum matrix order and the default inverter watchdog limit. IDXW is
// the row/col index width used on every host and inverter port.
package mstream_pkg;

    localparam int DW_DEF   = 16;
    localparam int MAXN_DEF = 16;
    localparam int TMO_DEF  = 65535;
    localparam int IDXW     = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RSTI = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        CAPT = 3'd4,
        FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/rc_counter.sv
// Row-major row/col walker over an N x N matrix.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   clear         - synchronous return to (0,0)
//   step          - advance one element
//   last_idx      - N-1 for the current job
//   row, col      - current element position
//   last          - high while sitting on element (N-1,N-1)
module rc_counter
    import mstream_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            step,
    input  logic [IDXW-1:0] last_idx,
    output logic [IDXW-1:0] row,
    output logic [IDXW-1:0] col,
    output logic            last
);

    assign last = (row == last_idx) && (col == last_idx);

    // Column wraps at last_idx and carries into row; the final element
    // wraps the pair back to (0,0).
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col == last_idx) begin
                col <= '0;
                if (row == last_idx) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_stream_host.sv
// Host-side controller that streams an N x N matrix to an external
// inverter and captures the inverse it returns.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   wr_en, wr_row, wr_col, wr_data    - host writes into the source buffer (IDLE only)
//   order, start                      - matrix order (1..MAXN) and job start pulse
//   rd_row, rd_col, rd_data           - combinational readback of the result buffer
//   busy, done, singular, err         - job status
//   inv_rst_n, inv_order, inv_data    - inverter reset, order and element stream
//   inv_ready, inv_result, inv_invertible - inverter response
// inv_order carries order[3:0], so order 16 appears there as 0.
module matrix_stream_host
    import mstream_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int MAXN = MAXN_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_row,
    input  logic [IDXW-1:0] wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic [4:0]      order,
    input  logic            start,
    input  logic [IDXW-1:0] rd_row,
    input  logic [IDXW-1:0] rd_col,
    output logic [DW-1:0]   rd_data,
    output logic            busy,
    output logic            done,
    output logic            singular,
    output logic            err,
    output logic            inv_rst_n,
    output logic [3:0]      inv_order,
    output logic [DW-1:0]   inv_data,
    input  logic            inv_ready,
    input  logic [DW-1:0]   inv_result,
    input  logic            inv_invertible
);

    localparam int WDW = $clog2(TMO + 1);

    state_t          state;
    logic [4:0]      n_r;
    logic            rsti_cnt;
    logic            tail;
    logic [WDW-1:0]  wd;
    logic [IDXW-1:0] last_idx;
    logic [IDXW-1:0] s_row, s_col, c_row, c_col;
    logic            s_last, c_last;
    logic            send_step, send_clear, cap_step, cap_clear;

    logic [DW-1:0] src [MAXN][MAXN];
    logic [DW-1:0] res [MAXN][MAXN];

    assign last_idx  = IDXW'(n_r - 5'd1);
    assign inv_order = n_r[3:0];
    assign rd_data   = res[rd_row][rd_col];

    // The send walker stops once the last element is issued (tail); the
    // remaining SEND cycle only drains inv_data back to zero.
    assign send_step  = (state == SEND) && !tail;
    assign send_clear = (state != SEND);
    // Capture starts in WAIT with (0,0) on the first accepted response.
    assign cap_step   = inv_ready && (((state == WAIT) && inv_invertible) || (state == CAPT));
    assign cap_clear  = (state != WAIT) && (state != CAPT);

    rc_counter u_send_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (send_clear),
        .step     (send_step),
        .last_idx (last_idx),
        .row      (s_row),
        .col      (s_col),
        .last     (s_last)
    );

    rc_counter u_cap_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cap_clear),
        .step     (cap_step),
        .last_idx (last_idx),
        .row      (c_row),
        .col      (c_col),
        .last     (c_last)
    );

    // Source buffer: host writes are honoured only while parked in IDLE.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && wr_en) begin
            src[wr_row][wr_col] <= wr_data;
        end
    end

    // Result buffer: one returned element per accepted capture cycle.
    always_ff @(posedge clk) begin
        if (cap_step && !rst) begin
            res[c_row][c_col] <= inv_result;
        end
    end

    // Job sequencer with registered status and inverter-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_r       <= '0;
            rsti_cnt  <= 1'b0;
            tail      <= 1'b0;
            wd        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            singular  <= 1'b0;
            err       <= 1'b0;
            inv_rst_n <= 1'b0;
            inv_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    inv_rst_n <= 1'b1;
                    inv_data  <= '0;
                    if (start) begin
                        if ((order == 5'd0) || (order > 5'(MAXN))) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            n_r       <= order;
                            singular  <= 1'b0;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            inv_rst_n <= 1'b0;
                            rsti_cnt  <= 1'b0;
                            state     <= RSTI;
                        end
                    end
                end
                RSTI: begin
                    // Two cycles of inverter reset, then release into SEND.
                    rsti_cnt <= 1'b1;
                    if (rsti_cnt) begin
                        inv_rst_n <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tail) begin
                        tail     <= 1'b0;
                        inv_data <= '0;
                        state    <= WAIT;
                    end else begin
                        inv_data <= src[s_row][s_col];
                        if (s_last) begin
                            tail <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (inv_ready) begin
                        wd <= '0;
                        if (!inv_invertible) begin
                            singular <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= FIN;
                        end else if (c_last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            state <= CAPT;
                        end
                    end else if (wd == WDW'(TMO - 1)) begin
                        wd    <= '0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                CAPT: begin
                    if (!inv_ready) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else if (c_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    inv_rst_n <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_host.sv
// Self-checking bench for matrix_stream_host. A job-level reference model
// predicts, per cycle after the accepting edge, the inverter reset window,
// the element stream, status flags and the final result buffer contents.
module tb_matrix_stream_host;

    localparam int DW   = 16;
    localparam int MAXN = 16;
    localparam int TMO  = 100;
    localparam int M_OK = 0, M_SING = 1, M_NEVER = 2, M_DROP = 3;

    logic          clk = 1'b0;
    logic          rst, wr_en, start;
    logic [3:0]    wr_row, wr_col, rd_row, rd_col, inv_order;
    logic [DW-1:0] wr_data, rd_data, inv_data, inv_result;
    logic [4:0]    order;
    logic          busy, done, singular, err, inv_rst_n, inv_ready, inv_invertible;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] src_m [MAXN][MAXN];
    logic [DW-1:0] res_m [MAXN][MAXN];
    bit            res_v [MAXN][MAXN];
    logic [DW-1:0] resp_q [$];

    always #5 clk = ~clk;

    matrix_stream_host #(.DW(DW), .MAXN(MAXN), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .order(order), .start(start), .rd_row(rd_row),
        .rd_col(rd_col), .rd_data(rd_data), .busy(busy), .done(done),
        .singular(singular), .err(err), .inv_rst_n(inv_rst_n), .inv_order(inv_order),
        .inv_data(inv_data), .inv_ready(inv_ready), .inv_result(inv_result),
        .inv_invertible(inv_invertible)
    );

    task automatic write_elem(input int r, input int c, input logic [DW-1:0] v);
        wr_en = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_data = v;
        src_m[r][c] = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_src(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                write_elem(r, c, DW'($urandom));
    endtask

    task automatic fill_resp(input int n);
        resp_q.delete();
        for (int i = 0; i < n * n; i++) resp_q.push_back(DW'($urandom));
    endtask

    // Runs one accepted job from the current negedge. Cycle k is the k-th
    // clock interval after the edge that accepts start. Expected timeline:
    // k=1,2 inverter reset; k=3 dead cycle; k=4..3+N*N elements; WAIT from
    // k=4+N*N; the inverter answers d cycles into WAIT.
    task automatic run_job(input int n, input int mode, input int d, input int j,
                           input bit stress, input string tag);
        int nn, w, f, idx;
        logic [DW-1:0] exp_data;
        bit exp_rstn, exp_busy, exp_done, exp_sing, exp_err;
        nn = n * n;
        w  = 4 + nn;
        case (mode)
            M_OK:    f = w + d + nn;
            M_SING:  f = w + d + 1;
            M_NEVER: f = w + TMO;
            default: f = w + d + j + 1;
        endcase
        start = 1'b1; order = 5'(n);
        for (int k = 1; k <= f + 1; k++) begin
            @(negedge clk);
            exp_rstn = !(k == 1 || k == 2);
            exp_data = (k >= 4 && k <= 3 + nn) ? src_m[(k - 4) / n][(k - 4) % n] : '0;
            exp_busy = (k < f);
            exp_done = (k == f);
            exp_sing = (mode == M_SING) && (k >= f);
            exp_err  = (mode == M_NEVER || mode == M_DROP) && (k >= f);
            n_cmp += 6;
            if (inv_rst_n !== exp_rstn) begin n_bad++; $display("FAIL %s inv_rst_n k=%0d got %b want %b", tag, k, inv_rst_n, exp_rstn); end
            if (inv_data !== exp_data) begin n_bad++; $display("FAIL %s inv_data k=%0d got %h want %h", tag, k, inv_data, exp_data); end
            if (busy !== exp_busy) begin n_bad++; $display("FAIL %s busy k=%0d got %b want %b", tag, k, busy, exp_busy); end
            if (done !== exp_done) begin n_bad++; $display("FAIL %s done k=%0d got %b want %b", tag, k, done, exp_done); end
            if (singular !== exp_sing) begin n_bad++; $display("FAIL %s singular k=%0d got %b want %b", tag, k, singular, exp_sing); end
            if (err !== exp_err) begin n_bad++; $display("FAIL %s err k=%0d got %b want %b", tag, k, err, exp_err); end
            if (k == 1) begin
                n_cmp++;
                if (inv_order !== 4'(n)) begin n_bad++; $display("FAIL %s inv_order got %h want %h", tag, inv_order, 4'(n)); end
            end
            // Drive inputs for interval k.
            start   = stress && (k == 5 || k == w + d + 1);
            order   = stress ? 5'd3 : 5'(n);
            wr_en   = stress && (k == 6);
            wr_row  = 4'd0; wr_col = 4'd0; wr_data = ~src_m[0][0];
            inv_ready = 1'b0; inv_invertible = 1'b1; inv_result = DW'($urandom);
            idx = k - (w + d);
            case (mode)
                M_OK:   if (idx >= 0 && idx < nn) begin inv_ready = 1'b1; inv_result = resp_q[idx]; end
                M_SING: if (idx == 0) begin inv_ready = 1'b1; inv_invertible = 1'b0; end
                M_DROP: if (idx >= 0 && idx < j) begin inv_ready = 1'b1; inv_result = resp_q[idx]; end
                default: ;
            endcase
        end
        start = 1'b0; wr_en = 1'b0; inv_ready = 1'b0;
        if (mode == M_OK || mode == M_DROP) begin
            for (int i = 0; i < ((mode == M_OK) ? nn : j); i++) begin
                res_m[i / n][i % n] = resp_q[i];
                res_v[i / n][i % n] = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; order = 5'd0; inv_ready = 1'b0;
        inv_invertible = 1'b0; inv_result = '0; rd_row = 4'd0; rd_col = 4'd0;
        wr_row = 4'd0; wr_col = 4'd0; wr_data = '0;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset done got %b want 0", done); end
        if (singular !== 1'b0) begin n_bad++; $display("FAIL reset singular got %b want 0", singular); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset err got %b want 0", err); end
        if (inv_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset inv_rst_n got %b want 0", inv_rst_n); end
        if (inv_data !== '0) begin n_bad++; $display("FAIL reset inv_data got %h want 0", inv_data); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (inv_rst_n !== 1'b1) begin n_bad++; $display("FAIL reset_release inv_rst_n got %b want 1", inv_rst_n); end
    endtask

    task automatic test_order2;
        write_elem(0, 0, 16'd2); write_elem(0, 1, 16'd0);
        write_elem(1, 0, 16'd0); write_elem(1, 1, 16'd4);
        resp_q = '{16'd1, 16'd0, 16'd0, 16'd1};
        run_job(2, M_OK, 3, 0, 1'b0, "order2");
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
            rd_row = 4'(r); rd_col = 4'(c); #1;
            n_cmp++;
            if (rd_data !== ((r == c) ? 16'd1 : 16'd0)) begin
                n_bad++; $display("FAIL order2 res[%0d][%0d] got %h want %h", r, c, rd_data, (r == c) ? 16'd1 : 16'd0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_singular;
        load_src(3);
        fill_resp(3);
        run_job(3, M_SING, 2, 0, 1'b0, "singular");
        for (int r = 0; r < MAXN; r++) for (int c = 0; c < MAXN; c++) if (res_v[r][c]) begin
            rd_row = 4'(r); rd_col = 4'(c); #1;
            n_cmp++;
            if (rd_data !== res_m[r][c]) begin n_bad++; $display("FAIL singular res[%0d][%0d] got %h want %h", r, c, rd_data, res_m[r][c]); end
        end
        @(negedge clk);
    endtask

    task automatic test_bad_order;
        logic [4:0] bad [3];
        bad = '{5'd0, 5'd17, 5'd31};
        for (int t = 0; t < 3; t++) begin
            start = 1'b1; order = bad[t];
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                start = 1'b0;
                n_cmp += 4;
                if (done !== (k == 1)) begin n_bad++; $display("FAIL bad_order%0d done k=%0d got %b want %b", bad[t], k, done, k == 1); end
                if (err !== 1'b1) begin n_bad++; $display("FAIL bad_order%0d err k=%0d got %b want 1", bad[t], k, err); end
                if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_order%0d busy k=%0d got %b want 0", bad[t], k, busy); end
                if (inv_rst_n !== 1'b1) begin n_bad++; $display("FAIL bad_order%0d inv_rst_n k=%0d got %b want 1", bad[t], k, inv_rst_n); end
            end
        end
    endtask

    task automatic test_watchdog;
        load_src(2);
        run_job(2, M_NEVER, 0, 0, 1'b0, "watchdog");
    endtask

    task automatic test_capture_drop;
        load_src(3);
        fill_resp(3);
        run_job(3, M_DROP, 1, 4, 1'b0, "drop");
        for (int r = 0; r < MAXN; r++) for (int c = 0; c < MAXN; c++) if (res_v[r][c]) begin
            rd_row = 4'(r); rd_col = 4'(c); #1;
            n_cmp++;
            if (rd_data !== res_m[r][c]) begin n_bad++; $display("FAIL drop res[%0d][%0d] got %h want %h", r, c, rd_data, res_m[r][c]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        load_src(16);
        fill_resp(16);
        run_job(16, M_OK, 3, 0, 1'b1, "b2b_first");
        fill_resp(16);
        run_job(16, M_OK, 0, 0, 1'b1, "b2b_second");
        for (int r = 0; r < MAXN; r++) for (int c = 0; c < MAXN; c++) if (res_v[r][c]) begin
            rd_row = 4'(r); rd_col = 4'(c); #1;
            n_cmp++;
            if (rd_data !== res_m[r][c]) begin n_bad++; $display("FAIL b2b res[%0d][%0d] got %h want %h", r, c, rd_data, res_m[r][c]); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job;
        load_src(3);
        start = 1'b1; order = 5'd3;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 4;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL rst_mid done got %b want 0", done); end
        if (inv_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_mid inv_rst_n got %b want 0", inv_rst_n); end
        if (inv_data !== '0) begin n_bad++; $display("FAIL rst_mid inv_data got %h want 0", inv_data); end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp += 3;
            if (done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after done k=%0d got %b want 0", k, done); end
            if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after busy k=%0d got %b want 0", k, busy); end
            if (inv_rst_n !== 1'b1) begin n_bad++; $display("FAIL rst_mid_after inv_rst_n k=%0d got %b want 1", k, inv_rst_n); end
        end
        for (int r = 0; r < MAXN; r++) for (int c = 0; c < MAXN; c++) res_v[r][c] = 1'b0;
        load_src(3);
        fill_resp(3);
        run_job(3, M_OK, 2, 0, 1'b0, "rst_mid_rerun");
        for (int r = 0; r < MAXN; r++) for (int c = 0; c < MAXN; c++) if (res_v[r][c]) begin
            rd_row = 4'(r); rd_col = 4'(c); #1;
            n_cmp++;
            if (rd_data !== res_m[r][c]) begin n_bad++; $display("FAIL rst_mid_rerun res[%0d][%0d] got %h want %h", r, c, rd_data, res_m[r][c]); end
        end
        @(negedge clk);
    endtask

    task automatic test_random_jobs;
        int n, mode, d, j;
        for (int t = 0; t < 5; t++) begin
            n = (t == 0) ? 1 : int'($urandom_range(2, 16));
            mode = (n == 1) ? M_OK : int'($urandom_range(0, 2));
            if (mode == 2) mode = M_DROP;
            d = int'($urandom_range(0, 4));
            j = (n > 1) ? int'($urandom_range(1, n * n - 1)) : 0;
            load_src(n);
            fill_resp(n);
            run_job(n, mode, d, j, 1'b0, "random");
            for (int r = 0; r < MAXN; r++) for (int c = 0; c < MAXN; c++) if (res_v[r][c]) begin
                rd_row = 4'(r); rd_col = 4'(c); #1;
                n_cmp++;
                if (rd_data !== res_m[r][c]) begin n_bad++; $display("FAIL random%0d res[%0d][%0d] got %h want %h", t, r, c, rd_data, res_m[r][c]); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_order2();
        test_singular();
        test_bad_order();
        test_watchdog();
        test_capture_drop();
        test_back_to_back();
        test_reset_mid_job();
        test_random_jobs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
